// File: rtl/cache_obi_arbiter_pkg.sv
// cache_obi_arbiter_pkg: shared types and constants for the cache OBI arbiter
package cache_obi_arbiter_pkg;
    localparam int CROC_ADDR_WIDTH    = 64;
    localparam int CROC_VALUE_WIDTH   = 128;
    localparam int ARB_TIMEOUT_CYCLES = 255;
    localparam int ARB_CNT_WIDTH      = 16;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
endpackage

// File: rtl/cache_obi_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick starting the search at ptr_i
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IW-1:0]      idx_o,
    output logic               any_o
);
    logic          w_found;
    logic [IW-1:0] w_j;
    // first requester at or after ptr_i, wrapping around
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        w_found = 1'b0;
        w_j     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_j = IW'((int'(ptr_i) + i) % NUM_REQ);
            if (!w_found && req_i[w_j]) begin
                w_found    = 1'b1;
                gnt_o[w_j] = 1'b1;
                idx_o      = w_j;
            end
        end
    end
    assign any_o = |req_i;
endmodule

// File: rtl/cache_obi_arbiter.sv
// cache_obi_arbiter: round-robin sharing of the cache OBI port, one transaction in flight
module cache_obi_arbiter
    import cache_obi_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = CROC_ADDR_WIDTH,
    parameter int VALUE_WIDTH    = CROC_VALUE_WIDTH,
    parameter int BE_WIDTH       = VALUE_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NUM_REQ-1:0]                    req_i,
    input  logic [NUM_REQ-1:0]                    we_i,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]    addr_i,
    input  logic [NUM_REQ-1:0][VALUE_WIDTH-1:0]   wdata_i,
    input  logic [NUM_REQ-1:0][BE_WIDTH-1:0]      be_i,
    output logic [NUM_REQ-1:0]                    gnt_o,
    output logic [NUM_REQ-1:0]                    rvalid_o,
    output logic [VALUE_WIDTH-1:0]                rdata_o,
    output logic                                  err_o,
    output logic                                  cache_req_o,
    output logic                                  cache_we_o,
    output logic [ADDR_WIDTH-1:0]                 cache_addr_o,
    output logic [VALUE_WIDTH-1:0]                cache_wdata_o,
    output logic [BE_WIDTH-1:0]                   cache_be_o,
    input  logic                                  cache_gnt_i,
    input  logic                                  cache_rvalid_i,
    input  logic                                  cache_err_i,
    input  logic [VALUE_WIDTH-1:0]                cache_rdata_i,
    output logic                                  timeout_o
);
    localparam int IW = $clog2(NUM_REQ);
    localparam logic [ARB_CNT_WIDTH-1:0] CNT_LAST = ARB_CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    arb_state_t               r_state;
    logic [IW-1:0]            r_ptr;
    logic [IW-1:0]            r_owner;
    logic [ARB_CNT_WIDTH-1:0] r_cnt;
    logic                     r_stale;
    logic                     r_timeout;
    logic                     r_we;
    logic [ADDR_WIDTH-1:0]    r_addr;
    logic [VALUE_WIDTH-1:0]   r_wdata;
    logic [BE_WIDTH-1:0]      r_be;
    logic [VALUE_WIDTH-1:0]   r_rdata;
    logic                     r_err;
    logic [NUM_REQ-1:0]       w_gnt;
    logic [IW-1:0]            w_idx;
    logic                     w_any;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_i (req_i),
        .ptr_i (r_ptr),
        .gnt_o (w_gnt),
        .idx_o (w_idx),
        .any_o (w_any)
    );

    // grant is only offered while idle and out of reset so it always matches a state advance
    assign gnt_o         = (r_state == IDLE && rst_ni) ? w_gnt : '0;
    assign rvalid_o      = (r_state == RESP) ? (NUM_REQ'(1) << r_owner) : '0;
    assign rdata_o       = r_rdata;
    assign err_o         = r_err;
    assign timeout_o     = r_timeout;
    assign cache_req_o   = (r_state == ISSUE) && !r_stale;
    assign cache_we_o    = r_we;
    assign cache_addr_o  = r_addr;
    assign cache_wdata_o = r_wdata;
    assign cache_be_o    = r_be;

    // transaction FSM; a late response after a timeout is swallowed via r_stale
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_cnt     <= '0;
            r_stale   <= 1'b0;
            r_timeout <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_be      <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            if (r_state != WAIT && cache_rvalid_i) r_stale <= 1'b0;
            case (r_state)
                IDLE: if (w_any) begin
                    r_owner <= w_idx;
                    r_we    <= we_i[w_idx];
                    r_addr  <= addr_i[w_idx];
                    r_wdata <= wdata_i[w_idx];
                    r_be    <= be_i[w_idx];
                    r_ptr   <= (w_idx == IW'(NUM_REQ - 1)) ? '0 : w_idx + IW'(1);
                    r_state <= ISSUE;
                end
                ISSUE: if (cache_gnt_i && !r_stale) begin
                    r_cnt   <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    r_cnt <= r_cnt + ARB_CNT_WIDTH'(1);
                    if (cache_rvalid_i) begin
                        r_rdata <= cache_rdata_i;
                        r_err   <= cache_err_i;
                        r_state <= RESP;
                    end else if (r_cnt == CNT_LAST) begin
                        r_rdata   <= '0;
                        r_err     <= 1'b1;
                        r_timeout <= 1'b1;
                        r_stale   <= 1'b1;
                        r_state   <= RESP;
                    end
                end
                RESP: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_obi_arbiter.sv
// tb_cache_obi_arbiter: directed scenario checks for the cache OBI arbiter
module tb_cache_obi_arbiter;
    logic               clk = 1'b0;
    logic               rst_ni = 1'b0;
    logic [3:0]         req_i = '0;
    logic [3:0]         we_i = '0;
    logic [3:0][63:0]   addr_i = '0;
    logic [3:0][127:0]  wdata_i = '0;
    logic [3:0][15:0]   be_i = '0;
    logic [3:0]         gnt_o;
    logic [3:0]         rvalid_o;
    logic [127:0]       rdata_o;
    logic               err_o;
    logic               cache_req_o;
    logic               cache_we_o;
    logic [63:0]        cache_addr_o;
    logic [127:0]       cache_wdata_o;
    logic [15:0]        cache_be_o;
    logic               cache_gnt_i = 1'b0;
    logic               cache_rvalid_i = 1'b0;
    logic               cache_err_i = 1'b0;
    logic [127:0]       cache_rdata_i = '0;
    logic               timeout_o;
    int                 n_pass = 0;
    int                 n_total = 0;

    cache_obi_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .err_o(err_o), .cache_req_o(cache_req_o), .cache_we_o(cache_we_o),
        .cache_addr_o(cache_addr_o), .cache_wdata_o(cache_wdata_o), .cache_be_o(cache_be_o),
        .cache_gnt_i(cache_gnt_i), .cache_rvalid_i(cache_rvalid_i), .cache_err_i(cache_err_i),
        .cache_rdata_i(cache_rdata_i), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input logic [3:0] rq, output logic [3:0] g);
        req_i = rq;
        #1;
        g = gnt_o;
        tick();
        req_i = '0;
        cache_gnt_i = 1'b1;
        tick();
        cache_gnt_i = 1'b0;
        cache_rvalid_i = 1'b1;
        cache_rdata_i = 128'h1;
        tick();
        cache_rvalid_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        #1;
        n_total++; if ({gnt_o, rvalid_o, cache_req_o, timeout_o, err_o} !== 11'b0) $display("FAIL reset_ctrl: got %b want 0", {gnt_o, rvalid_o, cache_req_o, timeout_o, err_o}); else n_pass++;
        n_total++; if ({rdata_o, cache_addr_o, cache_wdata_o, cache_be_o, cache_we_o} !== '0) $display("FAIL reset_data: got nonzero payload/rdata"); else n_pass++;
    endtask

    task automatic test_single_read();
        addr_i[2] = 64'h10;
        we_i = '0;
        req_i = 4'b0100;
        #1;
        n_total++; if (gnt_o !== 4'b0100) $display("FAIL read_gnt: got %b want 0100", gnt_o); else n_pass++;
        tick();
        req_i = '0;
        cache_gnt_i = 1'b1;
        n_total++; if ({cache_req_o, cache_we_o, cache_addr_o} !== {1'b1, 1'b0, 64'h10}) $display("FAIL read_issue: got req=%b we=%b addr=%h want 1 0 10", cache_req_o, cache_we_o, cache_addr_o); else n_pass++;
        tick();
        cache_gnt_i = 1'b0;
        tick();
        tick();
        cache_rvalid_i = 1'b1;
        cache_rdata_i = 128'hAB;
        n_total++; if (rvalid_o !== 4'b0000) $display("FAIL read_early_rvalid: got %b want 0000", rvalid_o); else n_pass++;
        tick();
        cache_rvalid_i = 1'b0;
        n_total++; if ({rvalid_o, err_o, rdata_o} !== {4'b0100, 1'b0, 128'hAB}) $display("FAIL read_resp: got rvalid=%b err=%b rdata=%h want 0100 0 ab", rvalid_o, err_o, rdata_o); else n_pass++;
        tick();
        n_total++; if (rvalid_o !== 4'b0000) $display("FAIL read_pulse_len: got %b want 0000", rvalid_o); else n_pass++;
    endtask

    task automatic test_fairness();
        logic [3:0] pend;
        logic [3:0] g;
        test_reset();
        pend = 4'hF;
        for (int i = 0; i < 4; i++) begin
            run_txn(pend, g);
            n_total++; if (g !== 4'(1 << i)) $display("FAIL fair_all_%0d: got %b want %b", i, g, 4'(1 << i)); else n_pass++;
            pend &= ~g;
        end
        run_txn(4'b0100, g);
        n_total++; if (g !== 4'b0100) $display("FAIL fair_set_ptr: got %b want 0100", g); else n_pass++;
        pend = 4'b0101;
        run_txn(pend, g);
        n_total++; if (g !== 4'b0001) $display("FAIL fair_wrap_first: got %b want 0001", g); else n_pass++;
        pend &= ~g;
        run_txn(pend, g);
        n_total++; if (g !== 4'b0100) $display("FAIL fair_wrap_second: got %b want 0100", g); else n_pass++;
    endtask

    task automatic test_backpressure();
        addr_i[1] = 64'h55;
        wdata_i[1] = 128'h1234;
        be_i[1] = 16'hFFFF;
        we_i = 4'b0010;
        req_i = 4'b0010;
        #1;
        n_total++; if (gnt_o !== 4'b0010) $display("FAIL bp_gnt: got %b want 0010", gnt_o); else n_pass++;
        tick();
        req_i = 4'b1000;
        addr_i[1] = 64'hDEAD;
        wdata_i[1] = 128'h9999;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_total++; if ({cache_req_o, cache_we_o, cache_addr_o, cache_wdata_o, cache_be_o, gnt_o} !== {1'b1, 1'b1, 64'h55, 128'h1234, 16'hFFFF, 4'b0000}) $display("FAIL bp_hold_%0d: got req=%b we=%b addr=%h wdata=%h be=%h gnt=%b want 1 1 55 1234 ffff 0000", c, cache_req_o, cache_we_o, cache_addr_o, cache_wdata_o, cache_be_o, gnt_o); else n_pass++;
            tick();
        end
        cache_gnt_i = 1'b1;
        tick();
        cache_gnt_i = 1'b0;
        cache_rvalid_i = 1'b1;
        cache_rdata_i = 128'h77;
        tick();
        cache_rvalid_i = 1'b0;
        n_total++; if ({rvalid_o, err_o, rdata_o} !== {4'b0010, 1'b0, 128'h77}) $display("FAIL bp_write_resp: got rvalid=%b err=%b rdata=%h want 0010 0 77", rvalid_o, err_o, rdata_o); else n_pass++;
        tick();
        n_total++; if (gnt_o !== 4'b1000) $display("FAIL bp_next_gnt: got %b want 1000", gnt_o); else n_pass++;
        req_i = '0;
        #1;
    endtask

    task automatic test_timeout_and_stale();
        we_i = '0;
        req_i = 4'b0001;
        #1;
        n_total++; if (gnt_o !== 4'b0001) $display("FAIL to_gnt: got %b want 0001", gnt_o); else n_pass++;
        tick();
        req_i = '0;
        cache_gnt_i = 1'b1;
        tick();
        cache_gnt_i = 1'b0;
        for (int c = 0; c < 7; c++) tick();
        n_total++; if ({timeout_o, rvalid_o} !== 5'b0) $display("FAIL to_early: got timeout=%b rvalid=%b want 0 0000", timeout_o, rvalid_o); else n_pass++;
        tick();
        n_total++; if ({timeout_o, rvalid_o, err_o, rdata_o} !== {1'b1, 4'b0001, 1'b1, 128'h0}) $display("FAIL to_resp: got timeout=%b rvalid=%b err=%b rdata=%h want 1 0001 1 0", timeout_o, rvalid_o, err_o, rdata_o); else n_pass++;
        tick();
        n_total++; if (timeout_o !== 1'b0) $display("FAIL to_pulse_len: got %b want 0", timeout_o); else n_pass++;
        req_i = 4'b0100;
        cache_gnt_i = 1'b1;
        #1;
        n_total++; if (gnt_o !== 4'b0100) $display("FAIL stale_gnt: got %b want 0100", gnt_o); else n_pass++;
        tick();
        req_i = '0;
        n_total++; if (cache_req_o !== 1'b0) $display("FAIL stale_hold_a: got %b want 0", cache_req_o); else n_pass++;
        tick();
        cache_rvalid_i = 1'b1;
        cache_rdata_i = 128'hBAD;
        n_total++; if ({cache_req_o, rvalid_o} !== 5'b0) $display("FAIL stale_hold_b: got req=%b rvalid=%b want 0 0000", cache_req_o, rvalid_o); else n_pass++;
        tick();
        cache_rvalid_i = 1'b0;
        n_total++; if ({cache_req_o, rvalid_o} !== {1'b1, 4'b0000}) $display("FAIL stale_drain: got req=%b rvalid=%b want 1 0000", cache_req_o, rvalid_o); else n_pass++;
        tick();
        cache_gnt_i = 1'b0;
        cache_rvalid_i = 1'b1;
        cache_rdata_i = 128'hC0DE;
        tick();
        cache_rvalid_i = 1'b0;
        n_total++; if ({rvalid_o, err_o, timeout_o, rdata_o} !== {4'b0100, 1'b0, 1'b0, 128'hC0DE}) $display("FAIL stale_next_resp: got rvalid=%b err=%b timeout=%b rdata=%h want 0100 0 0 c0de", rvalid_o, err_o, timeout_o, rdata_o); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_wait();
        addr_i[3] = 64'h3333;
        req_i = 4'b1000;
        #1;
        tick();
        req_i = '0;
        cache_gnt_i = 1'b1;
        tick();
        cache_gnt_i = 1'b0;
        tick();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        n_total++; if ({gnt_o, rvalid_o, cache_req_o, timeout_o, err_o, rdata_o, cache_addr_o} !== '0) $display("FAIL rst_wait_outputs: got gnt=%b rvalid=%b req=%b to=%b err=%b rdata=%h addr=%h want all 0", gnt_o, rvalid_o, cache_req_o, timeout_o, err_o, rdata_o, cache_addr_o); else n_pass++;
        cache_rvalid_i = 1'b1;
        tick();
        cache_rvalid_i = 1'b0;
        n_total++; if (rvalid_o !== 4'b0000) $display("FAIL rst_wait_no_resp: got %b want 0000", rvalid_o); else n_pass++;
        req_i = 4'b1111;
        #1;
        n_total++; if (gnt_o !== 4'b0001) $display("FAIL rst_wait_ptr: got %b want 0001", gnt_o); else n_pass++;
        req_i = '0;
        tick();
    endtask

    task automatic test_cache_error();
        req_i = 4'b0010;
        #1;
        n_total++; if (gnt_o !== 4'b0010) $display("FAIL err_gnt: got %b want 0010", gnt_o); else n_pass++;
        tick();
        req_i = '0;
        cache_gnt_i = 1'b1;
        tick();
        cache_gnt_i = 1'b0;
        cache_rvalid_i = 1'b1;
        cache_err_i = 1'b1;
        cache_rdata_i = 128'h5A5A;
        tick();
        cache_rvalid_i = 1'b0;
        cache_err_i = 1'b0;
        n_total++; if ({rvalid_o, err_o, timeout_o, rdata_o} !== {4'b0010, 1'b1, 1'b0, 128'h5A5A}) $display("FAIL err_resp: got rvalid=%b err=%b timeout=%b rdata=%h want 0010 1 0 5a5a", rvalid_o, err_o, timeout_o, rdata_o); else n_pass++;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_fairness();
        test_backpressure();
        test_timeout_and_stale();
        test_reset_mid_wait();
        test_cache_error();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
